lockctl: RTL and testbench
==========================

# lockctl

Parametrised digit-serial lock controller. Stores a DIGITS×DIGIT_W secret code and accepts the entered code one digit per handshake. It compares the full entry against the stored code and raises `equal` on a match. Consecutive failures are counted; MAX_TRIES failures trigger a timed lockout. It sits between the keypad scanner/debouncer and the door actuator logic. It generalises the 16-bit parallel lock comparator to configurable code length, serial entry, retry limiting and lockout.

## Interface
- DIGIT_W, 4: bits per digit.
- DIGITS, 4: digits per code; code width CW = DIGITS*DIGIT_W.
- MAX_TRIES, 3: consecutive failures that trigger lockout (≥1).
- LOCKOUT_CYCLES, 16: lockout duration in clk cycles (≥1).
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous, active-high reset.
- set  in  1  load `new_code` into the code register (accepted in SETUP and OPEN only).
- new_code  in  CW  code to store; digit 0 in the MS digit.
- digit_valid  in  1  one-cycle strobe: `digit` is presented this cycle.
- digit  in  DIGIT_W  entered digit.
- cancel  in  1  discard partial entry.
- relock  in  1  leave OPEN, return to ENTRY.
- equal  out  1  high while in OPEN.
- locked_out  out  1  high while in LOCKOUT.
- fail_cnt  out  $clog2(MAX_TRIES+1)  consecutive failures so far.
- digit_cnt  out  $clog2(DIGITS+1)  digits captured in the current entry.

## Operation
- States: SETUP, ENTRY, OPEN, LOCKOUT.
- Reset (clr=1):
  - state→SETUP; code register, entry shift register, digit_cnt, fail_cnt and lockout timer all go to 0.
  - Outputs: equal=0, locked_out=0, fail_cnt=0, digit_cnt=0.
- SETUP:
  - `digit_valid`, `cancel` and `relock` are ignored.
  - `set` loads `new_code` and moves to ENTRY.
- ENTRY:
  - On `digit_valid`, `digit` is shifted into the LS end of the entry register and digit_cnt increments.
  - On the DIGITS-th digit, the assembled entry (including that digit) is compared against the code register.
  - Match: go to OPEN; fail_cnt→0.
  - Mismatch: fail_cnt+1. If the new value equals MAX_TRIES, go to LOCKOUT; otherwise stay in ENTRY.
  - After the compare, digit_cnt and the entry register clear to 0.
  - `cancel` clears digit_cnt and the entry register. It does not change fail_cnt.
  - `set` is ignored in ENTRY.
- OPEN:
  - `set` loads `new_code`; state stays OPEN.
  - `relock` goes to ENTRY.
  - `digit_valid` is ignored.
- LOCKOUT:
  - The timer loads LOCKOUT_CYCLES-1 on entry and counts down.
  - At 0, go to ENTRY with fail_cnt→0.
  - All inputs except clr are ignored.
- Priority within one cycle: clr > cancel > set > relock > digit_valid.
  - `set` and `relock` together in OPEN: the code loads and the state goes to ENTRY.
  - `cancel` and `digit_valid` together in ENTRY: the digit is dropped and the entry is cleared.
- Comparison is exact over all CW bits. No partial-match information is exposed.

## Timing
- All outputs are registered and change only on a rising clk edge, or immediately on clr assertion.
- Final digit accepted at edge k: equal (or an updated fail_cnt) is visible after edge k, i.e. 1-cycle latency.
- Lockout:
  - locked_out rises after the edge that registers the MAX_TRIES-th failure.
  - It stays high for exactly LOCKOUT_CYCLES cycles.
  - A digit_valid in the first cycle after lockout ends is accepted.
- Back-to-back digit_valid (one per cycle) is supported with no bubbles. A new entry may start in the cycle immediately after a failed compare.
- digit_cnt never exceeds DIGITS. fail_cnt never exceeds MAX_TRIES; it wraps to 0 only on leaving LOCKOUT.
- clr mid-entry, mid-lockout or in OPEN returns everything to the reset values, including the stored code. Operation resumes from SETUP.

## Structure
- Shared package `lock_pkg`:
  - state encoding localparams (SETUP=2'd0, ENTRY=2'd1, OPEN=2'd2, LOCKOUT=2'd3);
  - default parameter values;
  - a width helper for the counters.
- Sub-module `lock_timer`: parametrised down-counter (load, enable, done pulse), instantiated once for the lockout.
- Top-level FSM, entry shift register and comparator stay in `lockctl`.

## Test plan
All scenarios use DIGIT_W=4, DIGITS=4, MAX_TRIES=3, LOCKOUT_CYCLES=8.
- Reset, set with new_code=16'h1234, enter 1,2,3,4 on consecutive cycles -> equal=1 one cycle after the last digit; fail_cnt=0.
- Code 16'h1234, enter 1,2,3,5 -> equal stays 0, fail_cnt=1, digit_cnt=0. A following 1,2,3,4 -> equal=1 and fail_cnt=0.
- Code 16'h1234, three wrong entries (16'h0000, 16'h1111, 16'h4321) -> locked_out=1 for exactly 8 cycles; digits during lockout ignored; then fail_cnt=0. A correct entry then opens.
- Enter 1,2, then cancel together with digit 3, then 1,2,3,4 -> digit_cnt=0 after cancel; equal=1 at the end.
- In OPEN, set with new_code=16'hABCD plus relock in the same cycle -> state ENTRY; 1,2,3,4 fails; A,B,C,D opens.
- clr asserted mid-lockout and between digits 2 and 3 -> all outputs 0 immediately. Digits before `set` are ignored; the stored code is 16'h0000 until reloaded.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the digit-serial lock controller: state encoding,
// default parameter values and the counter width helper.
package lock_pkg;

    typedef enum logic [1:0] {
        SETUP   = 2'd0,
        ENTRY   = 2'd1,
        OPEN    = 2'd2,
        LOCKOUT = 2'd3
    } lock_state_t;

    localparam int DEF_DIGIT_W        = 4;
    localparam int DEF_DIGITS         = 4;
    localparam int DEF_MAX_TRIES      = 3;
    localparam int DEF_LOCKOUT_CYCLES = 16;

    // Bits needed to hold any value 0..n inclusive (never less than 1).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; done is high while enabled and the count has reached zero.
module lock_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done = en && (count == '0);

endmodule

// File: rtl/lockctl.sv
// Digit-serial lock controller: serial code entry, exact compare against the
// stored code, consecutive-failure counting and a timed lockout.
module lockctl
    import lock_pkg::*;
#(
    parameter int DIGIT_W        = DEF_DIGIT_W,
    parameter int DIGITS         = DEF_DIGITS,
    parameter int MAX_TRIES      = DEF_MAX_TRIES,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          set,
    input  logic [DIGITS*DIGIT_W-1:0]     new_code,
    input  logic                          digit_valid,
    input  logic [DIGIT_W-1:0]            digit,
    input  logic                          cancel,
    input  logic                          relock,
    output logic                          equal,
    output logic                          locked_out,
    output logic [cnt_w(MAX_TRIES)-1:0]   fail_cnt,
    output logic [cnt_w(DIGITS)-1:0]      digit_cnt
);

    localparam int CW = DIGITS * DIGIT_W;
    localparam int FW = cnt_w(MAX_TRIES);
    localparam int DW = cnt_w(DIGITS);
    localparam int TW = cnt_w(LOCKOUT_CYCLES);

    lock_state_t   state, state_n;
    logic [CW-1:0] code, code_n;
    logic [CW-1:0] entry, entry_n, entry_shift;
    logic [DW-1:0] dcnt_n;
    logic [FW-1:0] fcnt_n, fcnt_inc;
    logic          tmr_load, tmr_en, tmr_done;

    assign entry_shift = (entry << DIGIT_W) | CW'(digit);
    assign fcnt_inc    = fail_cnt + FW'(1);
    assign tmr_en      = (state == LOCKOUT);

    lock_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .clr      (clr),
        .load     (tmr_load),
        .load_val (TW'(LOCKOUT_CYCLES - 1)),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= SETUP;
            code      <= '0;
            entry     <= '0;
            digit_cnt <= '0;
            fail_cnt  <= '0;
        end else begin
            state     <= state_n;
            code      <= code_n;
            entry     <= entry_n;
            digit_cnt <= dcnt_n;
            fail_cnt  <= fcnt_n;
        end
    end

    // Input priority: cancel > set > relock > digit_valid.
    always_comb begin
        state_n  = state;
        code_n   = code;
        entry_n  = entry;
        dcnt_n   = digit_cnt;
        fcnt_n   = fail_cnt;
        tmr_load = 1'b0;
        case (state)
            SETUP: begin
                if (set) begin
                    code_n  = new_code;
                    state_n = ENTRY;
                end
            end
            ENTRY: begin
                if (cancel) begin
                    entry_n = '0;
                    dcnt_n  = '0;
                end else if (digit_valid) begin
                    if (digit_cnt == DW'(DIGITS - 1)) begin
                        entry_n = '0;
                        dcnt_n  = '0;
                        if (entry_shift == code) begin
                            state_n = OPEN;
                            fcnt_n  = '0;
                        end else begin
                            fcnt_n = fcnt_inc;
                            if (fcnt_inc == FW'(MAX_TRIES)) begin
                                state_n  = LOCKOUT;
                                tmr_load = 1'b1;
                            end
                        end
                    end else begin
                        entry_n = entry_shift;
                        dcnt_n  = digit_cnt + DW'(1);
                    end
                end
            end
            OPEN: begin
                if (!cancel) begin
                    if (set) begin
                        code_n = new_code;
                    end
                    if (relock) begin
                        state_n = ENTRY;
                    end
                end
            end
            LOCKOUT: begin
                if (tmr_done) begin
                    state_n = ENTRY;
                    fcnt_n  = '0;
                end
            end
        endcase
    end

    assign equal      = (state == OPEN);
    assign locked_out = (state == LOCKOUT);

endmodule

// File: tb/tb_lockctl.sv
// Scoreboard bench for lockctl: expectations are queued when stimulus is
// driven and compared against the outputs on the falling edge they are due.
module tb_lockctl;

    logic        clk;
    logic        clr;
    logic        set;
    logic [15:0] new_code;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        cancel;
    logic        relock;
    logic        equal;
    logic        locked_out;
    logic [1:0]  fail_cnt;
    logic [2:0]  digit_cnt;

    lockctl #(
        .DIGIT_W        (4),
        .DIGITS         (4),
        .MAX_TRIES      (3),
        .LOCKOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .set         (set),
        .new_code    (new_code),
        .digit_valid (digit_valid),
        .digit       (digit),
        .cancel      (cancel),
        .relock      (relock),
        .equal       (equal),
        .locked_out  (locked_out),
        .fail_cnt    (fail_cnt),
        .digit_cnt   (digit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [63:0] tag;
        logic [6:0]  val;
    } exp_t;

    exp_t sb[$];
    exp_t mx;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model of the lock, at transaction level.
    int          m_state = 0;
    int          m_fail  = 0;
    int          m_dc    = 0;
    logic [15:0] m_code  = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Packed fields: {equal, locked_out, fail_cnt[1:0], digit_cnt[2:0]}.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mx = sb.pop_front();
            check($sformatf("%s@%0d", mx.tag, mx.cyc),
                  {25'd0, equal, locked_out, fail_cnt, digit_cnt}, {25'd0, mx.val});
        end
    end

    task automatic push_model(input logic [63:0] tag);
        exp_t x;
        x.cyc = cyc + 1;
        x.tag = tag;
        x.val = {(m_state == 2), (m_state == 3), 2'(m_fail), 3'(m_dc)};
        sb.push_back(x);
    endtask

    task automatic drive(input logic dv, input logic [3:0] d, input logic cn,
                         input logic st, input logic rl, input logic [15:0] nc);
        digit_valid = dv;
        digit       = d;
        cancel      = cn;
        set         = st;
        relock      = rl;
        new_code    = nc;
        @(posedge clk);
        #1;
        digit_valid = 1'b0;
        digit       = 4'h0;
        cancel      = 1'b0;
        set         = 1'b0;
        relock      = 1'b0;
        new_code    = 16'h0000;
    endtask

    task automatic enter_digit(input logic [3:0] d, input logic [63:0] tag);
        logic [15:0] assembled;
        if (m_state == 1) begin
            if (m_dc < 3) begin
                m_dc++;
            end else begin
                m_dc = 0;
            end
        end
        push_model(tag);
        drive(1'b1, d, 1'b0, 1'b0, 1'b0, 16'h0000);
        assembled = 16'h0;
    endtask

    task automatic enter_code(input logic [15:0] c, input logic [63:0] tag);
        logic [3:0] d;
        for (int i = 0; i < 4; i++) begin
            d = c[15-4*i -: 4];
            if (m_state == 1) begin
                if (i < 3) begin
                    m_dc = i + 1;
                end else begin
                    m_dc = 0;
                    if (c == m_code) begin
                        m_state = 2;
                        m_fail  = 0;
                    end else begin
                        m_fail++;
                        if (m_fail == 3) m_state = 3;
                    end
                end
            end
            push_model(tag);
            drive(1'b1, d, 1'b0, 1'b0, 1'b0, 16'h0000);
        end
    endtask

    task automatic do_set(input logic [15:0] nc, input logic rl);
        if (m_state == 0 || m_state == 2) begin
            m_code = nc;
            if (m_state == 0 || rl) m_state = 1;
        end
        push_model("set");
        drive(1'b0, 4'h0, 1'b0, 1'b1, rl, nc);
    endtask

    task automatic do_relock();
        if (m_state == 2) m_state = 1;
        push_model("relock");
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h0000);
    endtask

    task automatic lockout_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            push_model("lockwin");
            drive(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 16'h0000);
        end
    endtask

    task automatic do_clr(input string tag);
        @(negedge clk);
        #1;
        clr = 1'b1;
        #1;
        check({tag, "_eq"}, {31'd0, equal}, 32'd0);
        check({tag, "_lo"}, {31'd0, locked_out}, 32'd0);
        check({tag, "_fc"}, {30'd0, fail_cnt}, 32'd0);
        check({tag, "_dc"}, {29'd0, digit_cnt}, 32'd0);
        @(posedge clk);
        #1;
        clr     = 1'b0;
        m_state = 0;
        m_fail  = 0;
        m_dc    = 0;
        m_code  = 16'h0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr         = 1'b1;
        set         = 1'b0;
        new_code    = 16'h0000;
        digit_valid = 1'b0;
        digit       = 4'h0;
        cancel      = 1'b0;
        relock      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_eq", {31'd0, equal}, 32'd0);
        check("rst_lo", {31'd0, locked_out}, 32'd0);
        check("rst_fc", {30'd0, fail_cnt}, 32'd0);
        check("rst_dc", {29'd0, digit_cnt}, 32'd0);
        clr = 1'b0;

        // Digits in SETUP are ignored.
        enter_code(16'h1234, "setup_ig");
        do_set(16'h1234, 1'b0);
        enter_code(16'h1234, "open1");
        do_relock();

        // One failure, then a successful entry clears fail_cnt.
        enter_code(16'h1235, "fail1");
        enter_code(16'h1234, "open2");
        do_relock();

        // Three failures -> lockout window of 8 cycles, digits ignored.
        enter_code(16'h0000, "lk_a");
        enter_code(16'h1111, "lk_b");
        enter_code(16'h4321, "lk_c");
        lockout_cycles(7);
        m_state = 1;
        m_fail  = 0;
        push_model("lk_end");
        drive(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 16'h0000);
        enter_code(16'h1234, "after_lk");
        do_relock();

        // Cancel together with a digit drops the digit and clears the entry.
        enter_code(16'h1200, "part");
        m_state = 1;
        m_fail  = 1;
        do_clr("clr_part");
        do_set(16'h1234, 1'b0);
        enter_digit(4'h1, "p1");
        enter_digit(4'h2, "p2");
        m_dc = 0;
        push_model("cancel");
        drive(1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 16'h0000);
        enter_code(16'h1234, "open3");

        // set + relock together in OPEN: new code, back to ENTRY.
        do_set(16'hABCD, 1'b1);
        enter_code(16'h1234, "old_code");
        enter_code(16'hABCD, "new_code");
        do_relock();

        // clr mid-lockout.
        enter_code(16'h0000, "lk2_a");
        enter_code(16'h0001, "lk2_b");
        enter_code(16'h0002, "lk2_c");
        lockout_cycles(3);
        do_clr("clr_lk");
        enter_code(16'hABCD, "post_clr");
        do_set(16'h1234, 1'b0);

        // clr between digits 2 and 3; the remaining digits land in SETUP.
        enter_digit(4'h1, "q1");
        enter_digit(4'h2, "q2");
        do_clr("clr_mid");
        enter_digit(4'h3, "q3");
        enter_digit(4'h4, "q4");
        do_set(16'h1234, 1'b0);
        enter_code(16'h1234, "open4");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #1;
        if (sb.size() > 0) check("drain", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
